// File: rtl/ymultictrl.sv
// rtl/ymultictrl.sv - multi-cycle control sequencer for the yChip datapath
//
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It stalls on slow
// memory, takes interrupts at instruction boundaries and counts retired
// instructions.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ins                 instruction register contents (valid from DECODE on)
//   INT                 level interrupt request, sampled on the clock edge
//   mem_ready           memory completes the current access this cycle
//   zero                ALU zero flag (used in BEQ EXEC)
//   pc_write, pc_sel    PC load strobe / source (00 PC+4, 01 target, 10 entryPoint)
//   ir_write            latch fetched word into IR
//   RegDst .. jump      datapath control lines
//   op                  ALU op (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   int_ack             one-cycle pulse when the interrupt vector is taken
//   fault               sticky: illegal instruction or memory timeout
//   retired             instructions completed since reset (wraps)
module ymultictrl #(
    parameter int WAIT_MAX = 8,
    parameter int RET_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ins,
    input  logic             INT,
    input  logic             mem_ready,
    input  logic             zero,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             ir_write,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Mem2Reg,
    output logic             branch,
    output logic             jump,
    output logic [2:0]       op,
    output logic             int_ack,
    output logic             fault,
    output logic [RET_W-1:0] retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_INTR   = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    logic [2:0]       state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             int_pending_q, int_pending_d;
    logic [RET_W-1:0] retired_q, retired_d;
    logic             retire;

    // Instruction class decode
    logic [6:0] opc;
    logic [2:0] funct3;
    logic       is_r, is_i, is_lw, is_sw, is_beq, is_jal, legal_op;
    logic       f3_ok;
    logic [2:0] alu_op;

    assign opc      = ins[6:0];
    assign funct3   = ins[14:12];
    assign is_r     = (opc == 7'b0110011);
    assign is_i     = (opc == 7'b0010011);
    assign is_lw    = (opc == 7'b0000011);
    assign is_sw    = (opc == 7'b0100011);
    assign is_beq   = (opc == 7'b1100011);
    assign is_jal   = (opc == 7'b1101111);
    assign legal_op = is_r | is_i | is_lw | is_sw | is_beq | is_jal;

    always_comb begin
        f3_ok  = 1'b1;
        alu_op = OP_ADD;
        case (funct3)
            3'b000:  alu_op = (is_r && ins[30]) ? OP_SUB : OP_ADD;
            3'b111:  alu_op = OP_AND;
            3'b110:  alu_op = OP_OR;
            3'b010:  alu_op = OP_SLT;
            default: f3_ok  = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        int_pending_d = int_pending_q;
        retire        = 1'b0;

        case (state_q)
            S_FETCH, S_MEM: begin
                if (mem_ready) begin
                    wait_d = 8'd0;
                    if (state_q == S_FETCH) begin
                        state_d = S_DECODE;
                    end else if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    wait_d  = 8'd0;
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: state_d = legal_op ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_r || is_i) begin
                    state_d = f3_ok ? S_WB : S_TRAP;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_beq || is_jal) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_INTR:  state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        // Instruction boundary: a pending interrupt replaces the next fetch.
        // Leaving INTR itself is not a boundary, otherwise the pending bit
        // being cleared on that same edge would loop straight back.
        if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_INTR
                && int_pending_q) begin
            state_d = S_INTR;
        end

        // Set has priority over the clear in INTR
        if (state_q == S_INTR) begin
            int_pending_d = 1'b0;
        end
        if (INT && state_q != S_TRAP) begin
            int_pending_d = 1'b1;
        end

        retired_d = retired_q + {{(RET_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            wait_q        <= 8'd0;
            int_pending_q <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            int_pending_q <= int_pending_d;
            retired_q     <= retired_d;
        end
    end

    // Output decode from state and instruction. The fetch write enables are
    // qualified by mem_ready since IR/PC may only load on the completing cycle.
    always_comb begin
        pc_write = 1'b0;
        pc_sel   = 2'b00;
        ir_write = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Mem2Reg  = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        op       = OP_ADD;
        int_ack  = 1'b0;
        fault    = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_INTR: begin
                pc_write = 1'b1;
                pc_sel   = 2'b10;
                int_ack  = 1'b1;
            end
            S_EXEC, S_MEM, S_WB: begin
                // ALU controls stay put through MEM/WB so the result/address is stable
                if (is_r || is_i) begin
                    op     = alu_op;
                    ALUSrc = is_i;
                end else if (is_lw || is_sw) begin
                    ALUSrc = 1'b1;
                end else if (is_beq) begin
                    op = OP_SUB;
                end
                if (state_q == S_EXEC) begin
                    if (is_beq) begin
                        branch   = 1'b1;
                        pc_write = zero;
                        pc_sel   = zero ? 2'b01 : 2'b00;
                    end
                    if (is_jal) begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                        pc_sel   = 2'b01;
                        RegWrite = 1'b1;
                    end
                end else if (state_q == S_MEM) begin
                    MemRead  = is_lw;
                    MemWrite = is_sw;
                end else begin
                    RegWrite = 1'b1;
                    RegDst   = is_r;
                    Mem2Reg  = is_lw;
                end
            end
            S_TRAP:  fault = 1'b1;
            default: ;
        endcase

        // Hold every strobe low while reset is asserted
        if (!rst_n) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            fault    = 1'b0;
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_ymultictrl.sv
// tb/tb_ymultictrl.sv - directed self-checking bench for ymultictrl
module tb_ymultictrl;

    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_I = 5, P_T = 6;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_sel;
        logic       ir_write;
        logic       RegDst;
        logic       RegWrite;
        logic       ALUSrc;
        logic       MemRead;
        logic       MemWrite;
        logic       Mem2Reg;
        logic       branch;
        logic       jump;
        logic [2:0] op;
        logic       int_ack;
        logic       fault;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ins = 32'h0;
    logic        INT = 1'b0;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;
    logic        pc_write, ir_write, RegDst, RegWrite, ALUSrc;
    logic        MemRead, MemWrite, Mem2Reg, branch, jump, int_ack, fault;
    logic [1:0]  pc_sel;
    logic [2:0]  op;
    logic [31:0] retired;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_ret = 32'd0;
    logic        exp_pend = 1'b0;

    ymultictrl #(.WAIT_MAX(8), .RET_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .INT(INT), .mem_ready(mem_ready),
        .zero(zero), .pc_write(pc_write), .pc_sel(pc_sel), .ir_write(ir_write),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemRead(MemRead),
        .MemWrite(MemWrite), .Mem2Reg(Mem2Reg), .branch(branch), .jump(jump),
        .op(op), .int_ack(int_ack), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] f3_op(logic [31:0] in);
        case (in[14:12])
            3'b000:  return (in[6:0] == 7'h33 && in[30]) ? 3'b110 : 3'b010;
            3'b111:  return 3'b000;
            3'b110:  return 3'b001;
            3'b010:  return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit f3_legal(logic [31:0] in);
        return in[14:12] inside {3'b000, 3'b111, 3'b110, 3'b010};
    endfunction

    // Expected control lines for one phase of an instruction
    function automatic ctl_t model(int ph, logic [31:0] in, logic mr, logic z);
        ctl_t c;
        bit r   = (in[6:0] == 7'h33);
        bit i   = (in[6:0] == 7'h13);
        bit lw  = (in[6:0] == 7'h03);
        bit sw  = (in[6:0] == 7'h23);
        bit beq = (in[6:0] == 7'h63);
        bit jal = (in[6:0] == 7'h6F);
        c = '0;
        c.op = 3'b010;
        if (ph == P_E || ph == P_M || ph == P_W) begin
            if (r || i) c.op = f3_op(in);
            if (beq)    c.op = 3'b110;
            c.ALUSrc = i || lw || sw;
        end
        case (ph)
            P_F: begin c.MemRead = 1'b1; c.ir_write = mr; c.pc_write = mr; end
            P_E: begin
                if (beq) begin c.branch = 1'b1; c.pc_write = z; c.pc_sel = z ? 2'b01 : 2'b00; end
                if (jal) begin c.jump = 1'b1; c.pc_write = 1'b1; c.pc_sel = 2'b01; c.RegWrite = 1'b1; end
            end
            P_M: begin c.MemRead = lw; c.MemWrite = sw; end
            P_W: begin c.RegWrite = 1'b1; c.RegDst = r; c.Mem2Reg = lw; end
            P_I: begin c.pc_write = 1'b1; c.pc_sel = 2'b10; c.int_ack = 1'b1; end
            P_T: c.fault = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // One clock cycle: drive inputs, compare at negedge, advance model at posedge
    task automatic cyc(int ph, logic [31:0] in, logic it, logic mr, logic z);
        ctl_t e, a;
        bit sw, br;
        ins = in; INT = it; mem_ready = mr; zero = z;
        @(negedge clk);
        e = model(ph, in, mr, z);
        a = {pc_write, pc_sel, ir_write, RegDst, RegWrite, ALUSrc, MemRead,
             MemWrite, Mem2Reg, branch, jump, op, int_ack, fault};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL ctl ph=%0d ins=%h: got %h want %h", ph, in, a, e);
        end
        chk("retired", retired, exp_ret);
        @(posedge clk); #1;
        sw = (in[6:0] == 7'h23);
        br = (in[6:0] == 7'h63) || (in[6:0] == 7'h6F);
        if (ph == P_W || (ph == P_E && br) || (ph == P_M && sw && mr)) exp_ret++;
        if (ph == P_I) exp_pend = it;
        else if (it && ph != P_T) exp_pend = 1'b1;
    endtask

    // Whole instruction: fw fetch wait cycles, mw memory wait cycles,
    // int_e raises INT during EXEC
    task automatic run(logic [31:0] in, int fw, int mw, logic z, logic int_e);
        bit r  = (in[6:0] == 7'h33);
        bit i  = (in[6:0] == 7'h13);
        bit ls = (in[6:0] == 7'h03) || (in[6:0] == 7'h23);
        bit ok = r || i || ls || (in[6:0] == 7'h63) || (in[6:0] == 7'h6F);
        for (int k = 0; k < fw; k++) cyc(P_F, in, 1'b0, 1'b0, z);
        cyc(P_F, in, 1'b0, 1'b1, z);
        cyc(P_D, in, 1'b0, 1'b1, z);
        if (!ok) begin cyc(P_T, in, 1'b0, 1'b1, z); return; end
        cyc(P_E, in, int_e, 1'b1, z);
        if ((r || i) && !f3_legal(in)) begin cyc(P_T, in, 1'b0, 1'b1, z); return; end
        if (ls) begin
            for (int k = 0; k < mw; k++) cyc(P_M, in, 1'b0, 1'b0, z);
            cyc(P_M, in, 1'b0, 1'b1, z);
        end
        if (r || i || in[6:0] == 7'h03) cyc(P_W, in, 1'b0, 1'b1, z);
        if (exp_pend) cyc(P_I, in, 1'b0, 1'b1, z);
    endtask

    task automatic do_reset;
        rst_n = 1'b0; INT = 1'b0;
        #1;
        chk("rst_memread", MemRead, 0);
        chk("rst_memwrite", MemWrite, 0);
        chk("rst_fault", fault, 0);
        chk("rst_retired", retired, 0);
        chk("rst_op", op, 3'b010);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        exp_ret = 32'd0;
        exp_pend = 1'b0;
    endtask

    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] SUB  = 32'h402081B3;
    localparam logic [31:0] SLT  = 32'h0020A1B3;
    localparam logic [31:0] AND_ = 32'h0020F1B3;
    localparam logic [31:0] OR_  = 32'h0020E1B3;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] JAL  = 32'h008000EF;
    localparam logic [31:0] LW   = 32'h0000A183;
    localparam logic [31:0] SW   = 32'h0030A023;
    localparam logic [31:0] ADDI = 32'h00108093;
    localparam logic [31:0] SLLI = 32'h00109093;
    localparam logic [31:0] BAD  = 32'h0000007F;

    initial begin
        do_reset;

        run(ADD, 0, 0, 1'b0, 1'b0);
        chk("add_retired_literal", retired, 1);
        cyc(P_F, SUB, 1'b0, 1'b1, 1'b0);
        cyc(P_D, SUB, 1'b0, 1'b1, 1'b0);
        #2 chk("sub_op_literal", op, 3'b110);
        #1;
        cyc(P_E, SUB, 1'b0, 1'b1, 1'b0);
        cyc(P_W, SUB, 1'b0, 1'b1, 1'b0);
        run(SLT, 0, 0, 1'b0, 1'b0);
        run(AND_, 0, 0, 1'b0, 1'b0);
        run(OR_, 1, 0, 1'b0, 1'b0);
        run(BEQ, 0, 0, 1'b1, 1'b0);
        run(BEQ, 0, 0, 1'b0, 1'b0);
        run(JAL, 0, 0, 1'b0, 1'b0);
        run(LW, 0, 3, 1'b0, 1'b0);
        run(SW, 2, 1, 1'b0, 1'b0);
        chk("retired_literal", retired, 10);
        run(ADDI, 0, 0, 1'b0, 1'b1);
        run(ADD, 0, 0, 1'b0, 1'b0);

        run(SLLI, 0, 0, 1'b0, 1'b0);
        cyc(P_T, ADD, 1'b1, 1'b1, 1'b0);
        do_reset;

        run(BAD, 0, 0, 1'b0, 1'b0);
        chk("bad_fault_literal", fault, 1);
        cyc(P_T, ADD, 1'b1, 1'b1, 1'b0);
        cyc(P_T, ADD, 1'b0, 1'b0, 1'b0);
        do_reset;

        for (int k = 0; k < 8; k++) cyc(P_F, ADD, 1'b0, 1'b0, 1'b0);
        cyc(P_T, ADD, 1'b0, 1'b0, 1'b0);
        cyc(P_T, ADD, 1'b0, 1'b1, 1'b0);
        do_reset;

        run(ADD, 0, 0, 1'b0, 1'b0);
        cyc(P_F, SW, 1'b0, 1'b1, 1'b0);
        cyc(P_D, SW, 1'b0, 1'b1, 1'b0);
        cyc(P_E, SW, 1'b0, 1'b1, 1'b0);
        cyc(P_M, SW, 1'b0, 1'b0, 1'b0);
        mem_ready = 1'b0;
        #1 chk("sw_memwrite_held", MemWrite, 1);
        do_reset;
        run(ADD, 0, 0, 1'b0, 1'b0);
        chk("post_reset_retired", retired, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
